gray_step_arbiter: RTL and testbench

Shares one 3-bit Gray-code counter (ports Clk/Reset/En/Output/Overflow, synchronous active-high Reset) between two requesters.
- Each requester asks for a burst of N counting steps.
- The arbiter grants round-robin, clears the counter, drives En for exactly N cycles, then checks the counter's final Output/Overflow against the expected Gray value.
- Sits between the control logic and the counter instance; the counter is external.

---
 rtl/gray_step_arbiter_pkg.sv | 36 +++
 rtl/gray_step_arbiter_rr_arb2.sv | 24 ++
 rtl/gray_step_arbiter.sv | 135 +++++++++++++
 tb/tb_gray_step_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_step_arbiter_pkg.sv
// Shared definitions for the Gray-step arbiter: FSM states, 3-bit Gray
// constants and the binary-to-Gray helper.
package gray_step_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_STEP  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [2:0] GRAY_0 = 3'b000;
  localparam logic [2:0] GRAY_1 = 3'b001;
  localparam logic [2:0] GRAY_2 = 3'b011;
  localparam logic [2:0] GRAY_3 = 3'b010;
  localparam logic [2:0] GRAY_4 = 3'b110;
  localparam logic [2:0] GRAY_5 = 3'b111;
  localparam logic [2:0] GRAY_6 = 3'b101;
  localparam logic [2:0] GRAY_7 = 3'b100;

  function automatic logic [2:0] bin2gray(input logic [2:0] b);
    logic [2:0] g;
    case (b)
      3'd0:    g = GRAY_0;
      3'd1:    g = GRAY_1;
      3'd2:    g = GRAY_2;
      3'd3:    g = GRAY_3;
      3'd4:    g = GRAY_4;
      3'd5:    g = GRAY_5;
      3'd6:    g = GRAY_6;
      default: g = GRAY_7;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/gray_step_arbiter_rr_arb2.sv
// Two-input round-robin pick: a lone requester wins outright, a tie goes to
// the requester selected by ptr_i.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] pick_o,
  output logic       win_o
);

  always_comb begin
    win_o  = 1'b0;
    pick_o = 2'b00;
    case (req_i)
      2'b01:   win_o = 1'b0;
      2'b10:   win_o = 1'b1;
      2'b11:   win_o = ptr_i;
      default: win_o = 1'b0;
    endcase
    if (req_i != 2'b00) begin
      pick_o = win_o ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/gray_step_arbiter.sv
// Shares one external 3-bit Gray counter between two requesters: clears it,
// steps it Len times, then checks the final count against bin2gray(Len).
module gray_step_arbiter
  import gray_step_arbiter_pkg::*;
#(
  parameter int unsigned LEN_W = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [1:0]       Req,
  input  logic [LEN_W-1:0] Len0,
  input  logic [LEN_W-1:0] Len1,
  output logic [1:0]       Gnt,
  output logic             Busy,
  output logic             Done,
  output logic             DoneId,
  output logic [2:0]       Result,
  output logic             Ovf,
  output logic             Mismatch,
  output logic             Cnt_Reset,
  output logic             Cnt_En,
  input  logic [2:0]       Cnt_Output,
  input  logic             Cnt_Overflow
);

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rem_q;
  logic             win_q;
  logic             rr_q;
  logic [1:0]       gnt_q;
  logic             busy_q;
  logic             done_q;
  logic             doneid_q;
  logic [2:0]       result_q;
  logic             ovf_q;
  logic             mis_q;
  logic             cnt_rst_q;
  logic             cnt_en_q;

  logic [1:0]       pick;
  logic             win;
  logic [LEN_W+2:0] len_ext;
  logic [2:0]       gray_exp;
  logic             ovf_exp;
  logic             mis_d;

  rr_arb2 u_rr_arb2 (
    .req_i  (Req),
    .ptr_i  (rr_q),
    .pick_o (pick),
    .win_o  (win)
  );

  // Zero-extended so the mod-8 slice and the >=8 test work for any LEN_W.
  assign len_ext  = {3'b000, len_q};
  assign gray_exp = bin2gray(len_ext[2:0]);
  assign ovf_exp  = |len_ext[LEN_W+2:3];
  assign mis_d    = (Cnt_Output != gray_exp) | (Cnt_Overflow != ovf_exp);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      rem_q     <= '0;
      win_q     <= 1'b0;
      rr_q      <= 1'b0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      doneid_q  <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      mis_q     <= 1'b0;
      cnt_rst_q <= 1'b0;
      cnt_en_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Req != 2'b00) begin
            state_q   <= ST_CLEAR;
            gnt_q     <= pick;
            win_q     <= win;
            len_q     <= win ? Len1 : Len0;
            rem_q     <= win ? Len1 : Len0;
            busy_q    <= 1'b1;
            cnt_rst_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          cnt_rst_q <= 1'b0;
          if (len_q != '0) begin
            cnt_en_q <= 1'b1;
            state_q  <= ST_STEP;
          end else begin
            state_q  <= ST_DONE;
          end
        end
        ST_STEP: begin
          rem_q <= rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            cnt_en_q <= 1'b0;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Counter is final during this cycle; results appear with Done.
          done_q   <= 1'b1;
          doneid_q <= win_q;
          result_q <= Cnt_Output;
          ovf_q    <= Cnt_Overflow;
          mis_q    <= mis_d;
          rr_q     <= ~win_q;
          gnt_q    <= '0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Gnt       = gnt_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DoneId    = doneid_q;
  assign Result    = result_q;
  assign Ovf       = ovf_q;
  assign Mismatch  = mis_q;
  assign Cnt_Reset = cnt_rst_q;
  assign Cnt_En    = cnt_en_q;

endmodule

// File: tb/tb_gray_step_arbiter.sv
// Bench for gray_step_arbiter: behavioural Gray counter, burst-timeline model
// checked every cycle, directed bursts with literal results, random traffic.
module tb_gray_step_arbiter;

  localparam int unsigned LEN_W = 4;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [1:0] Req = 2'b00;
  logic [3:0] Len0 = 4'd0;
  logic [3:0] Len1 = 4'd0;
  logic [1:0] Gnt;
  logic       Busy, Done, DoneId, Ovf, Mismatch, Cnt_Reset, Cnt_En;
  logic [2:0] Result, Cnt_Output;
  logic       Cnt_Overflow;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int en_cycles = 0;
  logic chk_en = 1'b0;

  always #5 Clk = ~Clk;

  gray_step_arbiter #(.LEN_W(LEN_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Len0(Len0), .Len1(Len1),
    .Gnt(Gnt), .Busy(Busy), .Done(Done), .DoneId(DoneId), .Result(Result),
    .Ovf(Ovf), .Mismatch(Mismatch), .Cnt_Reset(Cnt_Reset), .Cnt_En(Cnt_En),
    .Cnt_Output(Cnt_Output), .Cnt_Overflow(Cnt_Overflow)
  );

  // External counter: binary count shown as Gray; stuck forces Output to 011.
  logic       stuck = 1'b0;
  logic [2:0] cb = 3'd0;
  logic       cov = 1'b0;
  assign Cnt_Output   = stuck ? 3'b011 : (cb ^ (cb >> 1));
  assign Cnt_Overflow = cov;

  always @(posedge Clk) begin
    cycle <= cycle + 1;
    if (Cnt_Reset) begin
      cb  <= 3'd0;
      cov <= 1'b0;
    end else if (Cnt_En) begin
      cb <= cb + 3'd1;
      if (cb == 3'd7) cov <= 1'b1;
    end
  end

  always @(negedge Clk) if (Cnt_En === 1'b1) en_cycles++;

  // Model: a burst is a timeline indexed by k = cycles since the grant edge.
  // k=0 clear, k=1..len stepping, k=len+1 checking, k=len+2 Done (idle again).
  logic       m_act = 1'b0;
  int         m_k = 0;
  int         m_len = 0;
  logic       m_win = 1'b0;
  logic       m_rr = 1'b0;
  logic       e_done = 1'b0, e_id = 1'b0, e_ovf = 1'b0, e_mis = 1'b0;
  logic [2:0] e_res = 3'd0;

  initial begin
    int g;
    forever begin
      @(posedge Clk or negedge Reset_n);
      e_done = 1'b0;
      e_mis  = 1'b0;
      if (!Reset_n) begin
        m_act = 1'b0; m_k = 0; m_rr = 1'b0;
        e_id = 1'b0; e_res = 3'd0; e_ovf = 1'b0;
      end else if (m_act) begin
        m_k++;
        if (m_k == m_len + 2) begin
          g      = m_len % 8;
          m_act  = 1'b0;
          e_done = 1'b1;
          e_id   = m_win;
          e_res  = stuck ? 3'b011 : 3'(g ^ (g >> 1));
          e_ovf  = (m_len >= 8);
          e_mis  = (e_res != 3'(g ^ (g >> 1))) || (e_ovf != (m_len >= 8));
          m_rr   = ~m_win;
        end
      end else if (Req != 2'b00) begin
        m_win = (Req == 2'b11) ? m_rr : Req[1];
        m_len = m_win ? int'(Len1) : int'(Len0);
        m_act = 1'b1;
        m_k   = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  logic [1:0] x_gnt;
  always @(negedge Clk) begin
    if (chk_en && Reset_n) begin
      x_gnt = m_act ? (m_win ? 2'b10 : 2'b01) : 2'b00;
      check("Gnt", 32'(Gnt), 32'(x_gnt));
      check("Busy", 32'(Busy), 32'(m_act));
      check("Cnt_Reset", 32'(Cnt_Reset), 32'(m_act && m_k == 0));
      check("Cnt_En", 32'(Cnt_En), 32'(m_act && m_k >= 1 && m_k <= m_len));
      check("Done", 32'(Done), 32'(e_done));
      if (e_done) check("DoneId", 32'(DoneId), 32'(e_id));
      check("Result", 32'(Result), 32'(e_res));
      check("Ovf", 32'(Ovf), 32'(e_ovf));
      check("Mismatch", 32'(Mismatch), 32'(e_mis));
    end
  end

  task automatic wait_gnt(output int t);
    bit seen;
    seen = 1'b0;
    t = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk);
      if (Gnt !== 2'b00) begin seen = 1'b1; t = cycle; end
    end
    if (!seen) begin
      errors++;
      $display("FAIL gnt_timeout: got no grant required a grant within 20 cycles");
    end
  endtask

  task automatic wait_done(output int t);
    bit seen;
    seen = 1'b0;
    t = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clk);
      if (Done === 1'b1) begin seen = 1'b1; t = cycle; end
    end
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no Done required Done within 40 cycles");
    end
  endtask

  int t_req, t_g, t_d, e0;
  logic [0:0] ids3 [3];
  logic [2:0] res3 [3];
  logic [0:0] ovf3 [3];

  initial begin
    ids3[0] = 1'b0; ids3[1] = 1'b1; ids3[2] = 1'b0;
    res3[0] = 3'b000; res3[1] = 3'b010; res3[2] = 3'b000;
    ovf3[0] = 1'b1; ovf3[1] = 1'b0; ovf3[2] = 1'b1;

    repeat (3) @(negedge Clk);
    chk_en = 1'b1;
    check("rst_Gnt", 32'(Gnt), 32'd0);
    check("rst_Busy", 32'(Busy), 32'd0);
    check("rst_Done", 32'(Done), 32'd0);
    check("rst_Result", 32'(Result), 32'd0);
    check("rst_CntEn", 32'(Cnt_En), 32'd0);
    #2 Reset_n = 1'b1;

    // 1: single burst, Len0=5
    @(negedge Clk); Req = 2'b01; Len0 = 4'd5; t_req = cycle; e0 = en_cycles;
    wait_gnt(t_g);
    check("t1_gnt_lat", 32'(t_g - t_req), 32'd1);
    check("t1_gnt", 32'(Gnt), 32'b01);
    Req = 2'b00;
    wait_done(t_d);
    check("t1_done_lat", 32'(t_d - t_g), 32'd7);
    check("t1_en_cycles", 32'(en_cycles - e0), 32'd5);
    check("t1_id", 32'(DoneId), 32'd0);
    check("t1_res", 32'(Result), 32'b111);
    check("t1_ovf", 32'(Ovf), 32'd0);
    check("t1_mis", 32'(Mismatch), 32'd0);

    // 2: Len1=0 goes straight from clear to done
    @(negedge Clk); Req = 2'b10; Len1 = 4'd0; e0 = en_cycles;
    wait_gnt(t_g);
    Req = 2'b00;
    wait_done(t_d);
    check("t2_done_lat", 32'(t_d - t_g), 32'd2);
    check("t2_en_cycles", 32'(en_cycles - e0), 32'd0);
    check("t2_id", 32'(DoneId), 32'd1);
    check("t2_res", 32'(Result), 32'b000);
    check("t2_ovf", 32'(Ovf), 32'd0);

    // 3: both requesting, grants alternate 0,1,0
    @(negedge Clk); Req = 2'b11; Len0 = 4'd8; Len1 = 4'd3;
    for (int b = 0; b < 3; b++) begin
      wait_done(t_d);
      if (b == 2) Req = 2'b00;
      check("t3_id", 32'(DoneId), 32'(ids3[b]));
      check("t3_res", 32'(Result), 32'(res3[b]));
      check("t3_ovf", 32'(Ovf), 32'(ovf3[b]));
      check("t3_mis", 32'(Mismatch), 32'd0);
    end

    // 4: counter output stuck at 011
    @(negedge Clk); stuck = 1'b1; Req = 2'b01; Len0 = 4'd2;
    wait_gnt(t_g); Req = 2'b00;
    wait_done(t_d);
    check("t4a_res", 32'(Result), 32'b011);
    check("t4a_mis", 32'(Mismatch), 32'd0);
    @(negedge Clk); Req = 2'b01; Len0 = 4'd4;
    wait_gnt(t_g); Req = 2'b00;
    wait_done(t_d);
    check("t4b_res", 32'(Result), 32'b011);
    check("t4b_mis", 32'(Mismatch), 32'd1);
    @(negedge Clk);
    check("t4b_mis_after", 32'(Mismatch), 32'd0);
    stuck = 1'b0;

    // 5: reset during a Len0=10 burst after the counter has wrapped
    @(negedge Clk); Req = 2'b01; Len0 = 4'd10;
    wait_gnt(t_g); Req = 2'b00;
    repeat (10) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("t5_gnt", 32'(Gnt), 32'd0);
    check("t5_busy", 32'(Busy), 32'd0);
    check("t5_en", 32'(Cnt_En), 32'd0);
    check("t5_res", 32'(Result), 32'd0);
    check("t5_stale_ovf", 32'(Cnt_Overflow), 32'd1);
    repeat (2) @(negedge Clk);
    #2 Reset_n = 1'b1;
    @(negedge Clk); Req = 2'b01; Len0 = 4'd1;
    wait_gnt(t_g); Req = 2'b00;
    wait_done(t_d);
    check("t5_res_after", 32'(Result), 32'b001);
    check("t5_ovf_after", 32'(Ovf), 32'd0);

    // 6: Req0 dropped mid-burst, Len inputs changed after grant
    @(negedge Clk); Req = 2'b01; Len0 = 4'd6;
    wait_gnt(t_g);
    repeat (2) @(negedge Clk);
    Req = 2'b10; Len0 = 4'd0; Len1 = 4'd15;
    wait_done(t_d);
    check("t6_id", 32'(DoneId), 32'd0);
    check("t6_res", 32'(Result), 32'b101);
    wait_gnt(t_g);
    check("t6_gnt1", 32'(Gnt), 32'b10);
    Req = 2'b00;
    wait_done(t_d);
    check("t6_res15", 32'(Result), 32'b100);
    check("t6_ovf15", 32'(Ovf), 32'd1);

    // Random traffic with occasional stuck counter and reset pulses
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      if (!Reset_n) #2 Reset_n = 1'b1;
      Req  = 2'($urandom_range(0, 3));
      Len0 = 4'($urandom);
      Len1 = 4'($urandom);
      if ($urandom_range(0, 19) == 0) stuck = ~stuck;
      if ($urandom_range(0, 399) == 0) #2 Reset_n = 1'b0;
    end
    @(negedge Clk);
    if (!Reset_n) #2 Reset_n = 1'b1;
    Req = 2'b00;
    repeat (25) @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got no end of test required completion before 500000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
